vga_text_window_core: RTL
=========================

// Module: vga_text_window_core
// PURPOSE
//  Parametrised text-overlay engine: COLS x ROWS character window, placeable and pixel-scalable, composited over an external background.
//  Per-character colour/opacity attribute; host write port with valid/ready handshake; hardware screen-clear FSM.
//  Sits between the VGA timing generator (xOrd/yOrd/visible) and the DAC outputs; replaces the fixed timer text core.
// PARAMETERS
//  COLS        80   characters per row (1..80)
//  ROWS        30   character rows (1..30)
//  SCALE_LOG2  0    pixel replication: cell = (8<<SCALE_LOG2) x (16<<SCALE_LOG2) pixels; 0..2
//  ORIGIN_X    0    window left edge, pixels
//  ORIGIN_Y    0    window top edge, pixels
//  ADDR_W      13   char address width; must satisfy 2**ADDR_W >= COLS*ROWS
// PORTS
//  clk        in   1       pixel clock
//  rst_n      in   1       async active-low reset
//  xOrd       in   10      current pixel column
//  yOrd       in   10      current pixel row
//  visible    in   1       active video
//  bgRed/bgGreen/bgBlue  in  8 each  background pixel for the same xOrd/yOrd
//  wrValid    in   1       host write request
//  wrReady    out  1       host write accept
//  wrAddr     in   ADDR_W  row*COLS+col
//  wrChar     in   7       ASCII code
//  wrAttr     in   4       [2:0] fg palette index, [3] opaque cell
//  clearReq   in   1       start full-window clear (pulse)
//  busy       out  1       clear in progress
//  errAddr    out  1       sticky: write with wrAddr >= COLS*ROWS accepted
//  red/green/blue  out  8 each  composited pixel
// BEHAVIOUR
//  Reset: red/green/blue=0, errAddr=0, wrReady=0, busy=1; FSM enters CLEAR (auto-clear after every reset).
//  FSM IDLE/CLEAR: CLEAR writes char 0x20, attr 0 to addr 0..COLS*ROWS-1, one per cycle, then -> IDLE.
//   busy=1 and wrReady=0 throughout CLEAR; wrReady=1 in IDLE.
//   clearReq in IDLE -> CLEAR next cycle (counter reset to 0); clearReq during CLEAR ignored (no restart).
//   clearReq and wrValid same cycle in IDLE: write accepted and performed, then clear runs (clear wins content).
//   Reset mid-clear: aborts, restarts clear from addr 0.
//  Write: transfer when wrValid&&wrReady; RAM updated that edge; in-range only. Out-of-range: accepted, no RAM change, errAddr<=1 (cleared only by reset).
//  Render pipeline, latency exactly 2 clocks from xOrd/yOrd/visible/bg* to red/green/blue:
//   S0: relX=xOrd-ORIGIN_X, relY=yOrd-ORIGIN_Y; inWin if 0<=rel< span; col=relX>>(3+SCALE_LOG2), row=relY>>(4+SCALE_LOG2); sync RAM read addr row*COLS+col.
//   S1: glyph row=(relY>>SCALE_LOG2)&15, bit=7-((relX>>SCALE_LOG2)&7); glyph ROM lookup, pixel bit.
//   S2 (registered): !visible -> 0; !inWin -> bg; glyph bit=1 -> palette[fg]; else opaque -> 0 (black); else bg.
//  Palette (3b idx -> RGB888): 0 blk,1 red,2 grn,3 yel,4 blu,5 mag,6 cyn,7 wht, channels 0x00/0xFF.
//  Host write and render read use separate RAM ports; same-address collision returns old data to render (read-first).
//  Characters >= 0x80 impossible (7 bits); codes 0x00-0x1F render blank.
// STRUCTURE
//  Package text_pkg: GLYPH_W=8, GLYPH_H=16, CHAR_SPACE=7'h20, palette constants, FSM state enum {IDLE,CLEAR}.
//  Sub-modules: text_char_ram (dual-port, 11-bit word {attr,char}, port A write, port B sync read); existing 8x16 font ROM reused as combinational glyph lookup.
//  Top holds FSM, clear counter, address arithmetic, 2-stage pipeline, compositing mux.
// TESTING
//  1 Reset released -> busy=1 for exactly COLS*ROWS cycles, wrReady=0 throughout, then busy=0/wrReady=1; full frame equals bg delayed 2 clk.
//  2 Write addr 0 'A'(0x41) attr 4'hF -> pixels (0..7,0..15) white where font bit set, black elsewhere in cell; (8,0) shows bg.
//  3 wrValid held during clear -> no transfer until wrReady rises; write lands first IDLE cycle; errAddr stays 0.
//  4 wrAddr=COLS*ROWS, 'B' -> accepted, errAddr=1, frame unchanged; stays 1 after later good writes, 0 after reset.
//  5 SCALE_LOG2=1, ORIGIN_X=100, ORIGIN_Y=50, 'A' attr 4'h1 at addr 0 -> glyph pixel (c,r) covers x 100+2c..+1, y 50+2r..+1 in red; x=99 shows bg.
//  6 visible toggled low for 1 cycle mid-glyph -> exactly one 0 output, 2 cycles later; reset asserted mid-clear -> clear restarts at addr 0.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, palette and compact 8x16 font for the text window core.
package text_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam logic [6:0] CHAR_SPACE = 7'h20;

    localparam logic [23:0] PAL_BLACK   = 24'h000000;
    localparam logic [23:0] PAL_RED     = 24'hFF0000;
    localparam logic [23:0] PAL_GREEN   = 24'h00FF00;
    localparam logic [23:0] PAL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] PAL_BLUE    = 24'h0000FF;
    localparam logic [23:0] PAL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] PAL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] PAL_WHITE   = 24'hFFFFFF;

    // Glyph bitmaps, row 0 in the most significant byte, pixel 0 in bit 7.
    localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = PAL_BLACK;
            3'd1:    rgb = PAL_RED;
            3'd2:    rgb = PAL_GREEN;
            3'd3:    rgb = PAL_YELLOW;
            3'd4:    rgb = PAL_BLUE;
            3'd5:    rgb = PAL_MAGENTA;
            3'd6:    rgb = PAL_CYAN;
            default: rgb = PAL_WHITE;
        endcase
        return rgb;
    endfunction

    // Combinational font lookup; unpopulated codes (including 0x00-0x1F) are blank.
    function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] row);
        logic [127:0] g;
        case (code)
            7'h41:   g = GLYPH_A;
            7'h42:   g = GLYPH_B;
            default: g = '0;
        endcase
        return g[{~row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/text_char_ram.sv
// Character/attribute RAM: word {attr[3:0], char[6:0]}, write port A, registered read port B.
module text_char_ram #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [10:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [10:0]       rdata
);

    logic [10:0] mem [2**ADDR_W];

    // Host/clear write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Render read port; a same-address write in this cycle is not yet visible (read-first)
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_text_window_core.sv
// Text overlay: character window over an external background, host write port,
// hardware screen clear, 2-clock render pipeline.
module vga_text_window_core
    import text_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int SCALE_LOG2 = 0,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        xOrd,
    input  logic [9:0]        yOrd,
    input  logic              visible,
    input  logic [7:0]        bgRed,
    input  logic [7:0]        bgGreen,
    input  logic [7:0]        bgBlue,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [6:0]        wrChar,
    input  logic [3:0]        wrAttr,
    input  logic              clearReq,
    output logic              busy,
    output logic              errAddr,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam int CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [12:0] OFS_X  = 13'(ORIGIN_X);
    localparam logic [12:0] OFS_Y  = 13'(ORIGIN_Y);
    localparam logic [12:0] SPAN_X = 13'(COLS * (GLYPH_W << SCALE_LOG2));
    localparam logic [12:0] SPAN_Y = 13'(ROWS * (GLYPH_H << SCALE_LOG2));
    localparam int COL_SHIFT = 3 + SCALE_LOG2;
    localparam int ROW_SHIFT = 4 + SCALE_LOG2;

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              host_xfer, host_in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [10:0]       ram_wdata;

    assign host_xfer     = wrValid && (state == IDLE);
    assign host_in_range = 32'(wrAddr) < 32'(CELLS);

    // FSM state register; every reset starts a fresh clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_next;
    end

    // FSM next state; clearReq while clearing is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clearReq) state_next = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // FSM outputs and RAM write port mux (clear has the port exclusively)
    always_comb begin
        busy      = (state == CLEAR);
        wrReady   = (state == IDLE);
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = {4'h0, CHAR_SPACE};
        if (state == CLEAR) begin
            ram_we = 1'b1;
        end else if (host_xfer && host_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = wrAddr;
            ram_wdata = {wrAttr, wrChar};
        end
    end

    // Clear address counter, parked at 0 while idle so a new clear starts at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_addr <= '0;
        else if (state == IDLE)  clr_addr <= '0;
        else                     clr_addr <= clr_addr + 1'b1;
    end

    // Sticky out-of-range write flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          errAddr <= 1'b0;
        else if (host_xfer && !host_in_range) errAddr <= 1'b1;
    end

    // ---- Stage 0: window test and character address ----
    logic [12:0]       rel_x_p0, rel_y_p0;
    logic              in_win_p0;
    logic [ADDR_W-1:0] col_p0, row_p0, rd_addr_p0;

    // Window-relative coordinates and cell address
    always_comb begin
        rel_x_p0   = {3'b000, xOrd} - OFS_X;
        rel_y_p0   = {3'b000, yOrd} - OFS_Y;
        in_win_p0  = ({3'b000, xOrd} >= OFS_X) && (rel_x_p0 < SPAN_X) &&
                     ({3'b000, yOrd} >= OFS_Y) && (rel_y_p0 < SPAN_Y);
        col_p0     = ADDR_W'(rel_x_p0 >> COL_SHIFT);
        row_p0     = ADDR_W'(rel_y_p0 >> ROW_SHIFT);
        rd_addr_p0 = row_p0 * ADDR_W'(COLS) + col_p0;
    end

    logic [10:0] cell_p1;

    text_char_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr_p0),
        .rdata (cell_p1)
    );

    // ---- Stage 1: glyph lookup and compositing ----
    logic        vis_p1, in_win_p1;
    logic [23:0] bg_p1;
    logic [3:0]  grow_p1;
    logic [2:0]  gcol_p1;
    logic [7:0]  row_bits_p1;
    logic        pix_on_p1;
    logic [23:0] rgb_p1;

    // Video-valid flag travelling with the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vis_p1 <= 1'b0;
        else        vis_p1 <= visible;
    end

    // Pixel data aligned with the RAM read
    always_ff @(posedge clk) begin
        in_win_p1 <= in_win_p0;
        bg_p1     <= {bgRed, bgGreen, bgBlue};
        grow_p1   <= 4'(rel_y_p0 >> SCALE_LOG2);
        gcol_p1   <= 3'(rel_x_p0 >> SCALE_LOG2);
    end

    // Glyph bit and priority compositing: blanking, window, foreground, opaque, background
    always_comb begin
        row_bits_p1 = font_row(cell_p1[6:0], grow_p1);
        pix_on_p1   = row_bits_p1[~gcol_p1];
        if (!vis_p1)         rgb_p1 = PAL_BLACK;
        else if (!in_win_p1) rgb_p1 = bg_p1;
        else if (pix_on_p1)  rgb_p1 = palette(cell_p1[9:7]);
        else if (cell_p1[10]) rgb_p1 = PAL_BLACK;
        else                 rgb_p1 = bg_p1;
    end

    // ---- Stage 2: registered DAC outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {red, green, blue} <= 24'h0;
        else        {red, green, blue} <= rgb_p1;
    end

endmodule
